// File: rtl/load_store_unit_if.sv
// Pipeline-side and Wishbone-side bundles of the load/store unit.
// The LSU is the slave of the pipeline bundle and the master of the Wishbone bundle.
interface lsu_pipe_if;
    logic        lsu_valid_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_op_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic [1:0]  lsu_exc_o;
    logic        lsu_busy_o;

    modport master (
        output lsu_valid_i, lsu_we_i, lsu_op_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_done_o, lsu_rdata_o, lsu_exc_o, lsu_busy_o
    );
    modport slave (
        input  lsu_valid_i, lsu_we_i, lsu_op_i, lsu_addr_i, lsu_wdata_i,
        output lsu_done_o, lsu_rdata_o, lsu_exc_o, lsu_busy_o
    );
endinterface

interface lsu_wb_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_addr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_sel_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );
    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_sel_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: decodes one pipeline memory op into one word-aligned
// Wishbone cycle, extends load data and maps misalignment/illegal/bus-error/timeout to exc codes.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    lsu_pipe_if.slave    lsu,
    lsu_wb_if.master     wbm
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        cyc_q, we_q, done_q, busy_q;
    logic [31:0] addr_q, dat_q, rdata_q;
    logic [3:0]  sel_q;
    logic [1:0]  exc_q;

    logic        illegal_d, misalign_d;
    logic [3:0]  sel_d;
    logic [31:0] dat_d, shifted_d, rdata_d;

    always_comb begin
        illegal_d  = (lsu.lsu_op_i == 3'b011) || (lsu.lsu_op_i[2:1] == 2'b11) ||
                     (lsu.lsu_we_i && lsu.lsu_op_i[2]);
        misalign_d = ((lsu.lsu_op_i[1:0] == 2'b01) && lsu.lsu_addr_i[0]) ||
                     ((lsu.lsu_op_i[1:0] == 2'b10) && (lsu.lsu_addr_i[1:0] != 2'b00));
        sel_d      = 4'b1111;
        dat_d      = lsu.lsu_wdata_i;
        case (lsu.lsu_op_i[1:0])
            2'b00: begin
                sel_d = 4'b0001 << lsu.lsu_addr_i[1:0];
                dat_d = {4{lsu.lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_d = 4'b0011 << lsu.lsu_addr_i[1:0];
                dat_d = {2{lsu.lsu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend by the latched op.
    always_comb begin
        shifted_d = wbm.wbm_dat_i >> {lane_q, 3'b000};
        case (op_q)
            3'b000:  rdata_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b001:  rdata_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  rdata_d = {24'd0, shifted_d[7:0]};
            3'b101:  rdata_d = {16'd0, shifted_d[15:0]};
            default: rdata_d = shifted_d;
        endcase
        if (we_q) rdata_d = 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 3'd0;
            lane_q  <= 2'd0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
            exc_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu.lsu_valid_i) begin
                        busy_q <= 1'b1;
                        if (illegal_d || misalign_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            rdata_q <= 32'd0;
                            exc_q   <= illegal_d ? 2'b11 : 2'b01;
                        end else begin
                            state_q <= BUS;
                            cnt_q   <= 8'd0;
                            op_q    <= lsu.lsu_op_i;
                            lane_q  <= lsu.lsu_addr_i[1:0];
                            cyc_q   <= 1'b1;
                            we_q    <= lsu.lsu_we_i;
                            addr_q  <= {lsu.lsu_addr_i[31:2], 2'b00};
                            sel_q   <= sel_d;
                            dat_q   <= dat_d;
                        end
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 8'd1;
                    // err beats ack; the timeout only fires when ack is absent in the last cycle.
                    if (wbm.wbm_err_i || (!wbm.wbm_ack_i && cnt_q == 8'(TIMEOUT - 1))) begin
                        state_q <= DONE;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= 32'd0;
                        exc_q   <= 2'b10;
                    end else if (wbm.wbm_ack_i) begin
                        state_q <= DONE;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= rdata_d;
                        exc_q   <= 2'b00;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wbm.wbm_cyc_o   = cyc_q;
    assign wbm.wbm_stb_o   = cyc_q;
    assign wbm.wbm_we_o    = we_q;
    assign wbm.wbm_addr_o  = addr_q;
    assign wbm.wbm_sel_o   = sel_q;
    assign wbm.wbm_dat_o   = dat_q;
    assign lsu.lsu_done_o  = done_q;
    assign lsu.lsu_rdata_o = rdata_q;
    assign lsu.lsu_exc_o   = exc_q;
    assign lsu.lsu_busy_o  = busy_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4); inputs driven and outputs sampled on the falling edge.
module tb_load_store_unit;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    lsu_pipe_if lsu();
    lsu_wb_if   wbm();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .lsu   (lsu),
        .wbm   (wbm)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          r_done_cyc, r_cyc_cnt, r_stable_bad, r_stb_bad;
    logic        r_we;
    logic [31:0] r_addr, r_dat, r_rdata;
    logic [3:0]  r_sel;
    logic [1:0]  r_exc;

    // Starts an op at the current falling edge (cycle 0) and runs until done or 40 cycles.
    // The responder answers in the (wait_n+1)-th cycle that cyc is seen high.
    task automatic do_op(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n, input logic ack,
                         input logic err, input logic [31:0] rsp);
        int  seen = 0;
        bit  got  = 0;
        lsu.lsu_valid_i = 1'b1;
        lsu.lsu_we_i    = we;
        lsu.lsu_op_i    = op;
        lsu.lsu_addr_i  = addr;
        lsu.lsu_wdata_i = wdata;
        wbm.wbm_dat_i   = rsp;
        wbm.wbm_ack_i   = 1'b0;
        wbm.wbm_err_i   = 1'b0;
        r_done_cyc = -1; r_stable_bad = 0; r_stb_bad = 0;
        r_we = 1'b0; r_addr = '0; r_dat = '0; r_sel = '0; r_rdata = 'x; r_exc = 'x;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk_i);
            wbm.wbm_ack_i = 1'b0;
            wbm.wbm_err_i = 1'b0;
            if (wbm.wbm_stb_o !== wbm.wbm_cyc_o) r_stb_bad++;
            if (wbm.wbm_cyc_o === 1'b1) begin
                seen++;
                if (seen == 1) begin
                    r_we = wbm.wbm_we_o; r_addr = wbm.wbm_addr_o;
                    r_sel = wbm.wbm_sel_o; r_dat = wbm.wbm_dat_o;
                end else if (r_we !== wbm.wbm_we_o || r_addr !== wbm.wbm_addr_o ||
                             r_sel !== wbm.wbm_sel_o || r_dat !== wbm.wbm_dat_o) begin
                    r_stable_bad++;
                end
                if (seen == wait_n + 1) begin
                    wbm.wbm_ack_i = ack;
                    wbm.wbm_err_i = err;
                end
            end
            if (lsu.lsu_done_o === 1'b1) begin
                got = 1;
                r_done_cyc = n;
                r_rdata = lsu.lsu_rdata_o;
                r_exc = lsu.lsu_exc_o;
                lsu.lsu_valid_i = 1'b0;
                wbm.wbm_ack_i = 1'b0;
                wbm.wbm_err_i = 1'b0;
            end
        end
        r_cyc_cnt = seen;
        if (!got) begin
            lsu.lsu_valid_i = 1'b0;
            $display("FAIL op_no_done: no lsu_done_o within 40 cycles (addr %h op %b)", addr, op);
        end
    endtask

    task automatic test_reset();
        lsu.lsu_valid_i = 1'b0; lsu.lsu_we_i = 1'b0; lsu.lsu_op_i = 3'd0;
        lsu.lsu_addr_i = '0; lsu.lsu_wdata_i = '0;
        wbm.wbm_dat_i = '0; wbm.wbm_ack_i = 1'b0; wbm.wbm_err_i = 1'b0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total_cnt++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o} !== 3'b000)
            $display("FAIL rst_cyc_stb_we got %b want 000", {wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o}); else pass_cnt++;
        total_cnt++; if ({wbm.wbm_addr_o, wbm.wbm_sel_o, wbm.wbm_dat_o} !== 68'd0)
            $display("FAIL rst_addr_sel_dat got %h/%b/%h want 0", wbm.wbm_addr_o, wbm.wbm_sel_o, wbm.wbm_dat_o); else pass_cnt++;
        total_cnt++; if ({lsu.lsu_done_o, lsu.lsu_busy_o, lsu.lsu_exc_o, lsu.lsu_rdata_o} !== 36'd0)
            $display("FAIL rst_lsu_outs got done %b busy %b exc %b rdata %h want 0", lsu.lsu_done_o, lsu.lsu_busy_o, lsu.lsu_exc_o, lsu.lsu_rdata_o); else pass_cnt++;
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_load_byte();
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b1, 1'b0, 32'h80FF_FFFF);
        total_cnt++; if (r_sel !== 4'b1000) $display("FAIL lb_sel got %b want 1000", r_sel); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h100) $display("FAIL lb_addr got %h want 00000100", r_addr); else pass_cnt++;
        total_cnt++; if (r_we !== 1'b0) $display("FAIL lb_we got %b want 0", r_we); else pass_cnt++;
        total_cnt++; if (r_done_cyc != 2) $display("FAIL lb_latency got %0d want 2", r_done_cyc); else pass_cnt++;
        total_cnt++; if (r_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %h want ffffff80", r_rdata); else pass_cnt++;
        total_cnt++; if (r_exc !== 2'b00) $display("FAIL lb_exc got %b want 00", r_exc); else pass_cnt++;
        @(negedge clk_i);
        total_cnt++; if ({lsu.lsu_done_o, lsu.lsu_busy_o} !== 2'b00)
            $display("FAIL lb_done_pulse got done %b busy %b want 0 0", lsu.lsu_done_o, lsu.lsu_busy_o); else pass_cnt++;
        do_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b1, 1'b0, 32'h80FF_FFFF);
        total_cnt++; if (r_rdata !== 32'h0000_0080) $display("FAIL lbu_rdata got %h want 00000080", r_rdata); else pass_cnt++;
        @(negedge clk_i);
        do_op(1'b0, 3'b001, 32'h102, 32'h0, 1, 1'b1, 1'b0, 32'h8001_7FFF);
        total_cnt++; if (r_rdata !== 32'hFFFF_8001) $display("FAIL lh_rdata got %h want ffff8001", r_rdata); else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_store_half();
        do_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        total_cnt++; if (r_we !== 1'b1) $display("FAIL sh_we got %b want 1", r_we); else pass_cnt++;
        total_cnt++; if (r_sel !== 4'b1100) $display("FAIL sh_sel got %b want 1100", r_sel); else pass_cnt++;
        total_cnt++; if (r_dat !== 32'hABCD_ABCD) $display("FAIL sh_dat got %h want abcdabcd", r_dat); else pass_cnt++;
        total_cnt++; if (r_addr !== 32'h200) $display("FAIL sh_addr got %h want 00000200", r_addr); else pass_cnt++;
        total_cnt++; if (r_cyc_cnt != 4 || r_done_cyc != 5)
            $display("FAIL sh_timing got cyc %0d done %0d want cyc 4 done 5", r_cyc_cnt, r_done_cyc); else pass_cnt++;
        total_cnt++; if (r_stable_bad != 0 || r_stb_bad != 0)
            $display("FAIL sh_stable got %0d changes %0d stb/cyc diffs want 0", r_stable_bad, r_stb_bad); else pass_cnt++;
        total_cnt++; if (r_exc !== 2'b00 || r_rdata !== 32'd0)
            $display("FAIL sh_result got exc %b rdata %h want 00 00000000", r_exc, r_rdata); else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_misaligned_illegal();
        do_op(1'b0, 3'b010, 32'h301, 32'h0, 0, 1'b1, 1'b0, 32'h0);
        total_cnt++; if (r_cyc_cnt != 0 || r_done_cyc != 1 || r_exc !== 2'b01)
            $display("FAIL mis_word got cyc %0d done %0d exc %b want 0 1 01", r_cyc_cnt, r_done_cyc, r_exc); else pass_cnt++;
        @(negedge clk_i);
        do_op(1'b1, 3'b001, 32'h105, 32'h0, 0, 1'b1, 1'b0, 32'h0);
        total_cnt++; if (r_cyc_cnt != 0 || r_done_cyc != 1 || r_exc !== 2'b01)
            $display("FAIL mis_half got cyc %0d done %0d exc %b want 0 1 01", r_cyc_cnt, r_done_cyc, r_exc); else pass_cnt++;
        @(negedge clk_i);
        do_op(1'b0, 3'b011, 32'h300, 32'h0, 0, 1'b1, 1'b0, 32'h0);
        total_cnt++; if (r_cyc_cnt != 0 || r_done_cyc != 1 || r_exc !== 2'b11 || r_rdata !== 32'd0)
            $display("FAIL ill_op got cyc %0d done %0d exc %b rdata %h want 0 1 11 0", r_cyc_cnt, r_done_cyc, r_exc, r_rdata); else pass_cnt++;
        @(negedge clk_i);
        do_op(1'b1, 3'b100, 32'h300, 32'h0, 0, 1'b1, 1'b0, 32'h0);
        total_cnt++; if (r_cyc_cnt != 0 || r_exc !== 2'b11)
            $display("FAIL ill_store_unsigned got cyc %0d exc %b want 0 11", r_cyc_cnt, r_exc); else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_bus_error();
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        total_cnt++; if (r_exc !== 2'b10 || r_rdata !== 32'd0 || r_done_cyc != 3)
            $display("FAIL err_resp got exc %b rdata %h done %0d want 10 0 3", r_exc, r_rdata, r_done_cyc); else pass_cnt++;
        @(negedge clk_i);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        total_cnt++; if (r_exc !== 2'b10 || r_rdata !== 32'd0)
            $display("FAIL ack_err_same got exc %b rdata %h want 10 0", r_exc, r_rdata); else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_timeout();
        do_op(1'b0, 3'b010, 32'h500, 32'h0, 0, 1'b0, 1'b0, 32'h1111_1111);
        total_cnt++; if (r_cyc_cnt != 4 || r_done_cyc != 5)
            $display("FAIL timeout_timing got cyc %0d done %0d want cyc 4 done 5", r_cyc_cnt, r_done_cyc); else pass_cnt++;
        total_cnt++; if (r_exc !== 2'b10 || r_rdata !== 32'd0)
            $display("FAIL timeout_exc got exc %b rdata %h want 10 0", r_exc, r_rdata); else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_bus();
        int spurious = 0;
        bit in_bus = 0;
        lsu.lsu_valid_i = 1'b1; lsu.lsu_we_i = 1'b1; lsu.lsu_op_i = 3'b010;
        lsu.lsu_addr_i = 32'h600; lsu.lsu_wdata_i = 32'h5555_AAAA;
        wbm.wbm_ack_i = 1'b0; wbm.wbm_err_i = 1'b0;
        for (int n = 0; n < 3 && !in_bus; n++) begin
            @(negedge clk_i);
            if (wbm.wbm_cyc_o === 1'b1) in_bus = 1;
        end
        total_cnt++; if (!in_bus) $display("FAIL rstbus_enter got cyc %b want 1", wbm.wbm_cyc_o); else pass_cnt++;
        rst_i = 1'b0;
        lsu.lsu_valid_i = 1'b0;
        @(negedge clk_i);
        total_cnt++; if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o, wbm.wbm_addr_o, wbm.wbm_dat_o} !== 71'd0)
            $display("FAIL rstbus_wbm got cyc %b stb %b we %b sel %b addr %h dat %h want 0", wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o, wbm.wbm_sel_o, wbm.wbm_addr_o, wbm.wbm_dat_o); else pass_cnt++;
        total_cnt++; if ({lsu.lsu_done_o, lsu.lsu_busy_o} !== 2'b00)
            $display("FAIL rstbus_lsu got done %b busy %b want 0 0", lsu.lsu_done_o, lsu.lsu_busy_o); else pass_cnt++;
        rst_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            if (lsu.lsu_done_o !== 1'b0 || wbm.wbm_cyc_o !== 1'b0) spurious++;
        end
        total_cnt++; if (spurious != 0) $display("FAIL rstbus_no_done got %0d active cycles want 0", spurious); else pass_cnt++;
        do_op(1'b0, 3'b010, 32'h0, 32'h0, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
        total_cnt++; if (r_rdata !== 32'hCAFE_F00D || r_sel !== 4'b1111 || r_exc !== 2'b00)
            $display("FAIL post_rst_lw got rdata %h sel %b exc %b want cafef00d 1111 00", r_rdata, r_sel, r_exc); else pass_cnt++;
    endtask

    // Entered at the DONE falling edge of the previous op: valid re-raised there must wait for IDLE.
    task automatic test_back_to_back();
        do_op(1'b1, 3'b000, 32'h701, 32'h0000_00A5, 0, 1'b1, 1'b0, 32'h0);
        total_cnt++; if (r_done_cyc != 3) $display("FAIL b2b_latency got %0d want 3", r_done_cyc); else pass_cnt++;
        total_cnt++; if (r_sel !== 4'b0010 || r_dat !== 32'hA5A5_A5A5 || r_addr !== 32'h700)
            $display("FAIL b2b_req got sel %b dat %h addr %h want 0010 a5a5a5a5 00000700", r_sel, r_dat, r_addr); else pass_cnt++;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned_illegal();
        test_bus_error();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side load/store unit sitting directly upstream of the Wishbone bridge. It accepts one memory operation at a time from the execute/memory stage and turns it into a single word-aligned Wishbone request with byte selects and lane-replicated store data. It extracts and sign- or zero-extends load data, detects misaligned and illegal-size accesses, and converts bus errors and bus timeouts into exception codes returned to the pipeline.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in BUS without ack/err before a bus-error is forced; range 2..255 (8-bit counter).

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-low reset
- lsu_valid_i  in  1  operation request; held with all lsu_* inputs stable until lsu_done_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_op_i  in  3  size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, value in low bits
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_rdata_o  out  32  extended load data, valid while lsu_done_o=1
- lsu_exc_o  out  2  00 none, 01 misaligned, 10 bus error/timeout, 11 illegal op; valid while lsu_done_o=1
- lsu_busy_o  out  1  state != IDLE
- wbm_cyc_o, wbm_stb_o  out  1  request to bridge
- wbm_we_o  out  1  write enable
- wbm_addr_o  out  32  word address, bits [1:0] = 00
- wbm_sel_o  out  4  byte lanes
- wbm_dat_o  out  32  lane-replicated store data
- wbm_dat_i  in  32  read data from bridge
- wbm_ack_i  in  1  transfer complete
- wbm_err_i  in  1  transfer error

## Operation
- States: IDLE, BUS, DONE. All outputs registered.
- IDLE, lsu_valid_i=1: decode.
  - Illegal op (011, 110, 111; stores with bit 2 set are also illegal): go DONE, exc=11, no bus cycle.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠00): go DONE, exc=01, no bus cycle.
  - Otherwise: latch wbm_addr_o={addr[31:2],2'b00} and wbm_we_o=lsu_we_i. Sel: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata. Assert cyc/stb, clear timeout counter, go BUS.
- BUS: cyc/stb held, all wbm_* outputs stable; the counter increments each cycle.
  - wbm_err_i=1, or counter reaches TIMEOUT-1 with no ack: drop cyc/stb, exc=10, go DONE.
  - wbm_ack_i=1: drop cyc/stb, exc=00, go DONE.
  - Loads: shift wbm_dat_i right by 8*addr[1:0], then extend to 32 bits (sign for 000/001, zero for 100/101, none for word) into lsu_rdata_o.
  - Stores: lsu_rdata_o=0.
- DONE: lsu_done_o=1 for exactly one cycle, then IDLE. lsu_valid_i is ignored in DONE.
- Error responses return lsu_rdata_o=0.
- ack and err in the same cycle: err wins.
- ack/err outside BUS: ignored.

## Timing
- Reset (rst_i=0 at an edge): state IDLE; all outputs 0, including cyc, stb, we, addr, sel, dat, done, rdata, exc, busy. Counter 0.
- Reset mid-BUS: cyc/stb low after that edge; no done pulse is produced.
- Latency: valid seen in IDLE at cycle 0 → cyc/stb high in cycle 1 → ack in cycle k≥1 → done in cycle k+1. Minimum 2 cycles from valid to done.
- Misaligned/illegal: done in cycle 1 and no cyc ever asserted.
- Timeout: with no response, cyc stays high for exactly TIMEOUT cycles and done follows in the next cycle.
- Back-to-back: a new valid is accepted in the first IDLE cycle after DONE, so throughput is one operation per 3 cycles minimum.

## Test plan
- Load byte signed: addr=0x103, op=000, bus returns 0x80FFFFFF with ack in cycle 1 → sel=1000, addr_o=0x100, done in cycle 2, rdata=0xFFFFFF80, exc=00. The same with op=100 → rdata=0x00000080.
- Store half: addr=0x202, op=001, wdata=0x1234ABCD, ack after 3 wait cycles → we=1, sel=1100, dat_o=0xABCDABCD, done 1 cycle after ack, exc=00.
- Misaligned word: addr=0x301, op=010 → no cyc, done in cycle 1 with exc=01. Illegal op=011 → done in cycle 1 with exc=11.
- Bus error plus simultaneous ack/err: err in BUS → exc=10, rdata=0. ack and err in the same cycle → exc=10.
- Timeout with TIMEOUT=4 and no response → cyc high for exactly 4 cycles, then done with exc=10.
- rst_i low during BUS → cyc/stb and all outputs 0 next cycle, no done pulse. After reset, a word load at 0x0 with ack returns data unmodified.
